// File: rtl/sram_sp_param.sv
// Parametrised single-port synchronous SRAM with per-bit write mask, read-valid strobe,
// selectable read-during-write behaviour and a sequential clear engine.
module sram_sp_param #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 12,
    parameter int RDW_MODE    = 0,
    parameter int INIT_ON_RST = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] wmask_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic              rej_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam state_t            RST_STATE = (INIT_ON_RST != 0) ? CLEAR : IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] clrCnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              clrDone_q;
    logic              rej_q;

    logic              idle;
    logic              plainRead;
    logic              bypassRead;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memBitEn;
    logic [DATA_W-1:0] mergedWord_d;

    // The clear engine owns the single port while busy; user accesses only reach it in IDLE.
    always_comb begin
        idle         = (state_q == IDLE);
        plainRead    = rd_en_i & ~wr_en_i;
        bypassRead   = rd_en_i & wr_en_i & (RDW_MODE != 0);
        mergedWord_d = (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
        memWe        = rst_i & (idle ? wr_en_i : 1'b1);
        memAddr      = idle ? addr_i  : clrCnt_q;
        memWdata     = idle ? wdata_i : '0;
        memBitEn     = idle ? wmask_i : '1;
    end

    always_ff @(posedge clk_i) begin
        if (memWe) begin
            for (int b = 0; b < DATA_W; b++) begin
                if (memBitEn[b]) begin
                    mem[memAddr][b] <= memWdata[b];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RST_STATE;
            clrCnt_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            clrDone_q <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            rvalid_q  <= 1'b0;
            clrDone_q <= 1'b0;
            rej_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (plainRead) begin
                        rdata_q  <= mem[addr_i];
                        rvalid_q <= 1'b1;
                    end else if (bypassRead) begin
                        rdata_q  <= mergedWord_d;
                        rvalid_q <= 1'b1;
                    end
                    if (clr_i) begin
                        state_q  <= CLEAR;
                        clrCnt_q <= '0;
                    end
                end
                CLEAR: begin
                    // Requests during a clear are dropped; a repeated clr_i never restarts it.
                    rej_q <= clr_i | wr_en_i | rd_en_i;
                    if (clrCnt_q == LAST_ADDR) begin
                        state_q   <= IDLE;
                        clrCnt_q  <= '0;
                        clrDone_q <= 1'b1;
                    end else begin
                        clrCnt_q <= clrCnt_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign busy_o     = (state_q == CLEAR);
    assign clr_done_o = clrDone_q;
    assign rej_o      = rej_q;

endmodule
